// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the forwarding-select and controller-state enums plus the NOP encoding.
package pipe_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_M  = 2'b01,
      FWD_W  = 2'b10
   } fwd_sel_e;

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      DRAIN = 2'b01,
      HALT  = 2'b10
   } ctrl_state_e;

   localparam logic [31:0] NOP_INSN = 32'h00000013;

   // Width needed to hold a down-counter preloaded with n (never below 1 bit).
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Decode/execute/memory/writeback hazard signals exchanged with pipe_ctrl.
// The pipeline datapath is the master; pipe_ctrl is the slave.
interface pipe_ctrl_if #(
   parameter int REG_AW = 5
);

   logic [REG_AW-1:0]  d_rs1;
   logic [REG_AW-1:0]  d_rs2;
   logic               d_use_rs1;
   logic               d_use_rs2;
   logic               d_is_ecall;
   logic [REG_AW-1:0]  e_rs1;
   logic [REG_AW-1:0]  e_rs2;
   logic [REG_AW-1:0]  e_rd;
   logic [REG_AW-1:0]  m_rd;
   logic [REG_AW-1:0]  w_rd;
   logic               e_wen;
   logic               m_wen;
   logic               w_wen;
   logic               e_is_load;
   logic               e_redirect;

   logic               f_stall;
   logic               d_stall;
   logic               fd_flush;
   logic               de_bubble;
   pipe_pkg::fwd_sel_e fwd_a;
   pipe_pkg::fwd_sel_e fwd_b;
   logic               halt;
   logic [31:0]        stall_cnt;

   modport master (
      output d_rs1, d_rs2, d_use_rs1, d_use_rs2, d_is_ecall,
      output e_rs1, e_rs2, e_rd, m_rd, w_rd,
      output e_wen, m_wen, w_wen, e_is_load, e_redirect,
      input  f_stall, d_stall, fd_flush, de_bubble,
      input  fwd_a, fwd_b, halt, stall_cnt
   );

   modport slave (
      input  d_rs1, d_rs2, d_use_rs1, d_use_rs2, d_is_ecall,
      input  e_rs1, e_rs2, e_rd, m_rd, w_rd,
      input  e_wen, m_wen, w_wen, e_is_load, e_redirect,
      output f_stall, d_stall, fd_flush, de_bubble,
      output fwd_a, fwd_b, halt, stall_cnt
   );

endinterface

// File: rtl/fwd_sel.sv
// Operand forwarding selector for one execute-stage source register.
// The M-stage result wins over W; register 0 is never forwarded.
module fwd_sel
   import pipe_pkg::*;
#(
   parameter int AW = 5
) (
   input  logic [AW-1:0] i_rs,
   input  logic [AW-1:0] i_m_rd,
   input  logic          i_m_wen,
   input  logic [AW-1:0] i_w_rd,
   input  logic          i_w_wen,
   output fwd_sel_e      o_sel
);

   logic w_m_hit;
   logic w_w_hit;

   assign w_m_hit = i_m_wen && (i_m_rd != '0) && (i_m_rd == i_rs);
   assign w_w_hit = i_w_wen && (i_w_rd != '0) && (i_w_rd == i_rs);

   always_comb begin
      o_sel = FWD_RF;
      if (w_m_hit) begin
         o_sel = FWD_M;
      end else if (w_w_hit) begin
         o_sel = FWD_W;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller: load-use/RAW stalls, redirect flush,
// operand forwarding and ecall drain-to-halt. Macro PIPE_CTRL_FWD_EN enables forwarding.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int REG_AW    = 5,
   parameter int DRAIN_CYC = 3
) (
   input  logic        clk,
   input  logic        reset,
   pipe_ctrl_if.slave  bus
);

`ifdef PIPE_CTRL_FWD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   localparam int CNT_W = cnt_width(DRAIN_CYC);

   ctrl_state_e       r_state;
   logic [CNT_W-1:0]  r_drain_cnt;
   logic [31:0]       r_stall_cnt;
   logic              r_halt;

   logic [REG_AW-1:0] w_src_rd  [3];
   logic              w_src_wen [3];
   logic [2:0]        w_src_hit;
   logic              w_load_use;
   logic              w_hazard;
   fwd_sel_e          w_fwd_a;
   fwd_sel_e          w_fwd_b;
   fwd_sel_e          w_fwd_a_out;
   fwd_sel_e          w_fwd_b_out;
   logic              w_f_stall;
   logic              w_d_stall;
   logic              w_fd_flush;
   logic              w_de_bubble;

   // Source index 0/1/2 = E/M/W producers checked against the decode operands.
   assign w_src_rd[0]  = bus.e_rd;
   assign w_src_rd[1]  = bus.m_rd;
   assign w_src_rd[2]  = bus.w_rd;
   assign w_src_wen[0] = bus.e_wen;
   assign w_src_wen[1] = bus.m_wen;
   assign w_src_wen[2] = bus.w_wen;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_src
         assign w_src_hit[gi] = w_src_wen[gi] && (w_src_rd[gi] != '0) &&
                                ((bus.d_use_rs1 && (w_src_rd[gi] == bus.d_rs1)) ||
                                 (bus.d_use_rs2 && (w_src_rd[gi] == bus.d_rs2)));
      end
   endgenerate

   // Without forwarding every in-flight producer is a hazard, not just a load in E.
   assign w_load_use = bus.e_is_load && w_src_hit[0];
   assign w_hazard   = FWD_EN ? w_load_use : (|w_src_hit);

   fwd_sel #(.AW(REG_AW)) u_fwd_a (
      .i_rs    (bus.e_rs1),
      .i_m_rd  (bus.m_rd),
      .i_m_wen (bus.m_wen),
      .i_w_rd  (bus.w_rd),
      .i_w_wen (bus.w_wen),
      .o_sel   (w_fwd_a)
   );

   fwd_sel #(.AW(REG_AW)) u_fwd_b (
      .i_rs    (bus.e_rs2),
      .i_m_rd  (bus.m_rd),
      .i_m_wen (bus.m_wen),
      .i_w_rd  (bus.w_rd),
      .i_w_wen (bus.w_wen),
      .o_sel   (w_fwd_b)
   );

   assign w_fwd_a_out = FWD_EN ? w_fwd_a : FWD_RF;
   assign w_fwd_b_out = FWD_EN ? w_fwd_b : FWD_RF;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= RUN;
         r_drain_cnt <= '0;
         r_stall_cnt <= '0;
         r_halt      <= 1'b0;
      end else begin
         case (r_state)
            RUN: begin
               if (w_hazard && !bus.e_redirect && (r_stall_cnt != '1)) begin
                  r_stall_cnt <= r_stall_cnt + 32'd1;
               end
               if (bus.d_is_ecall && !bus.e_redirect && !w_hazard) begin
                  r_state     <= DRAIN;
                  r_drain_cnt <= CNT_W'(DRAIN_CYC);
               end
            end
            DRAIN: begin
               r_drain_cnt <= r_drain_cnt - CNT_W'(1);
               if (r_drain_cnt <= CNT_W'(1)) begin
                  r_state     <= HALT;
                  r_drain_cnt <= '0;
                  r_halt      <= 1'b1;
               end
            end
            HALT: begin
               r_halt <= 1'b1;
            end
            default: begin
               r_state <= RUN;
            end
         endcase
      end
   end

   always_comb begin
      w_f_stall   = 1'b0;
      w_d_stall   = 1'b0;
      w_fd_flush  = 1'b0;
      w_de_bubble = 1'b0;
      bus.fwd_a   = FWD_RF;
      bus.fwd_b   = FWD_RF;
      if (!reset) begin
         case (r_state)
            RUN: begin
               bus.fwd_a = w_fwd_a_out;
               bus.fwd_b = w_fwd_b_out;
               if (bus.e_redirect) begin
                  w_fd_flush  = 1'b1;
                  w_de_bubble = 1'b1;
               end else if (w_hazard) begin
                  w_f_stall   = 1'b1;
                  w_d_stall   = 1'b1;
                  w_de_bubble = 1'b1;
               end
            end
            DRAIN: begin
               // Older instructions still flow through E/M/W, so they keep forwarding.
               bus.fwd_a   = w_fwd_a_out;
               bus.fwd_b   = w_fwd_b_out;
               w_f_stall   = 1'b1;
               w_de_bubble = 1'b1;
            end
            HALT: begin
               w_f_stall = 1'b1;
               w_d_stall = 1'b1;
            end
            default: begin
               w_f_stall = 1'b0;
            end
         endcase
      end
   end

   assign bus.f_stall   = w_f_stall;
   assign bus.d_stall   = w_d_stall;
   assign bus.fd_flush  = w_fd_flush;
   assign bus.de_bubble = w_de_bubble;
   assign bus.halt      = r_halt;
   assign bus.stall_cnt = r_stall_cnt;

endmodule
